// File: rtl/coin_stage_sequencer_pkg.sv
// rtl/coin_stage_sequencer_pkg.sv - shared state encoding and default parameters
package coin_stage_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_CREDIT_W   = 5;
  localparam int DEF_NUM_STAGES = 9;
  localparam int DEF_DONE_HOLD  = 8;

endpackage

// File: rtl/btn_debounce_pulse.sv
// rtl/btn_debounce_pulse.sv - synchronizer, debouncer and rising-edge pulse for one raw button
module btn_debounce_pulse
  import coin_stage_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      // any sample agreeing with the current level restarts the stability count
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      deb_d <= deb;
      pulse <= deb & ~deb_d;
    end
  end

endmodule

// File: rtl/coin_stage_sequencer.sv
// rtl/coin_stage_sequencer.sv - button conditioning, credit accumulation and stage FSM
module coin_stage_sequencer
  import coin_stage_sequencer_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int CREDIT_W   = DEF_CREDIT_W,
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int DONE_HOLD  = DEF_DONE_HOLD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_in,
  input  logic                adv_in,
  input  logic [CREDIT_W-1:0] sw_price,
  output logic [3:0]          stage,
  output logic [CREDIT_W-1:0] credit,
  output logic                has_credit,
  output logic                busy,
  output logic                done,
  output logic                denied
);

  localparam int                  HOLD_W     = $clog2(DONE_HOLD + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;

  logic                coin_p;
  logic                adv_p;
  state_t              state;
  state_t              state_nx;
  logic [3:0]          stage_nx;
  logic [CREDIT_W-1:0] credit_base;
  logic [CREDIT_W-1:0] credit_nx;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nx;
  logic                denied_nx;

  btn_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_coin (
    .clk   (clk),
    .rst   (rst),
    .btn   (coin_in),
    .pulse (coin_p)
  );

  btn_debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_adv (
    .clk   (clk),
    .rst   (rst),
    .btn   (adv_in),
    .pulse (adv_p)
  );

  assign has_credit = (credit >= sw_price);

  always_comb begin
    state_nx    = state;
    stage_nx    = stage;
    hold_nx     = hold_cnt;
    denied_nx   = 1'b0;
    credit_base = credit;
    case (state)
      ST_IDLE: begin
        stage_nx = 4'd0;
        if (adv_p) begin
          if (has_credit) begin
            state_nx    = ST_RUN;
            stage_nx    = 4'd1;
            credit_base = credit - sw_price;
          end else begin
            denied_nx = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (adv_p) begin
          if (stage < 4'(NUM_STAGES)) begin
            stage_nx = stage + 4'd1;
          end else begin
            state_nx = ST_DONE;
            hold_nx  = '0;
          end
        end
      end
      ST_DONE: begin
        if (hold_cnt == HOLD_W'(DONE_HOLD - 1)) begin
          state_nx = ST_IDLE;
          stage_nx = 4'd0;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        stage_nx = 4'd0;
      end
    endcase
    // a coin landing with a run start is added after the price is taken
    credit_nx = credit_base;
    if (coin_p && (credit_base != CREDIT_MAX)) begin
      credit_nx = credit_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      stage    <= 4'd0;
      credit   <= '0;
      hold_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      denied   <= 1'b0;
    end else begin
      state    <= state_nx;
      stage    <= stage_nx;
      credit   <= credit_nx;
      hold_cnt <= hold_nx;
      busy     <= (state_nx != ST_IDLE);
      done     <= (state_nx == ST_DONE);
      denied   <= denied_nx;
    end
  end

endmodule

// File: tb/tb_coin_stage_sequencer.sv
// tb/tb_coin_stage_sequencer.sv - self-checking bench for coin_stage_sequencer
module tb_coin_stage_sequencer;

  localparam int DEB  = 4;
  localparam int W    = 5;
  localparam int NSTG = 9;
  localparam int HOLD = 8;
  localparam int CMAX = 31;

  logic         clk = 1'b0;
  logic         rst;
  logic         coin_in;
  logic         adv_in;
  logic [W-1:0] sw_price;
  logic [3:0]   stage;
  logic [W-1:0] credit;
  logic         has_credit;
  logic         busy;
  logic         done;
  logic         denied;

  int errs   = 0;
  int checks = 0;
  int den_seen;
  int done_seen;

  // reference state: button histories, stability windows and run bookkeeping
  int raw_h[2][2];
  int win[2][DEB];
  int deb_m[2];
  int pipe[2][2];
  int st_m, stage_m, credit_m, denied_m, left_m;

  always #5 clk = ~clk;

  coin_stage_sequencer #(
    .DEB_CYCLES (DEB),
    .CREDIT_W   (W),
    .NUM_STAGES (NSTG),
    .DONE_HOLD  (HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_in    (coin_in),
    .adv_in     (adv_in),
    .sw_price   (sw_price),
    .stage      (stage),
    .credit     (credit),
    .has_credit (has_credit),
    .busy       (busy),
    .done       (done),
    .denied     (denied)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic c, input logic a);
    int p[2];
    int raw[2];
    int samp, all_diff, rose, start, nc;
    raw[0] = int'(c);
    raw[1] = int'(a);
    denied_m = 0;
    if (r) begin
      for (int b = 0; b < 2; b++) begin
        raw_h[b][0] = 0; raw_h[b][1] = 0;
        pipe[b][0]  = 0; pipe[b][1]  = 0;
        deb_m[b]    = 0;
        for (int i = 0; i < DEB; i++) win[b][i] = 0;
      end
      st_m = 0; stage_m = 0; credit_m = 0; left_m = 0;
      return;
    end
    for (int b = 0; b < 2; b++) begin
      samp = raw_h[b][1];
      raw_h[b][1] = raw_h[b][0];
      raw_h[b][0] = raw[b];
      for (int i = DEB - 1; i > 0; i--) win[b][i] = win[b][i-1];
      win[b][0] = samp;
      all_diff = 1;
      for (int i = 0; i < DEB; i++) if (win[b][i] == deb_m[b]) all_diff = 0;
      rose = 0;
      if (all_diff != 0) begin
        deb_m[b] = 1 - deb_m[b];
        rose = deb_m[b];
      end
      p[b] = pipe[b][1];
      pipe[b][1] = pipe[b][0];
      pipe[b][0] = rose;
    end
    start = 0;
    case (st_m)
      0: if (p[1] != 0) begin
           if (credit_m >= int'(sw_price)) begin
             start = 1; st_m = 1; stage_m = 1;
           end else begin
             denied_m = 1;
           end
         end
      1: if (p[1] != 0) begin
           if (stage_m < NSTG) stage_m++;
           else begin st_m = 2; left_m = HOLD; end
         end
      default: begin
        left_m--;
        if (left_m == 0) begin st_m = 0; stage_m = 0; end
      end
    endcase
    nc = credit_m - (start != 0 ? int'(sw_price) : 0);
    if (p[0] != 0) nc = (nc + 1 > CMAX) ? CMAX : nc + 1;
    credit_m = nc;
  endtask

  task automatic tick(input logic r, input logic c, input logic a);
    @(negedge clk);
    rst = r; coin_in = c; adv_in = a;
    @(posedge clk);
    model_edge(r, c, a);
    #1;
    check_val("stage", int'(stage), stage_m);
    check_val("credit", int'(credit), credit_m);
    check_val("has_credit", int'(has_credit), int'(credit_m >= int'(sw_price)));
    check_val("busy", int'(busy), int'(st_m != 0));
    check_val("done", int'(done), int'(st_m == 2));
    check_val("denied", int'(denied), denied_m);
    if (denied) den_seen++;
    if (done) done_seen++;
  endtask

  task automatic press(input logic c, input logic a);
    repeat (6) tick(1'b0, c, a);
    repeat (6) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'(i % 2), 1'(1 - (i % 2)));
    check_val("rst_stage", int'(stage), 0);
    check_val("rst_credit", int'(credit), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_denied", int'(denied), 0);
  endtask

  initial begin
    int lvl[2];
    int rem[2];
    rst = 1'b1; coin_in = 1'b0; adv_in = 1'b0; sw_price = '0;

    // glitches shorter than the debounce window, then exact press latency
    do_reset();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'((i / 2) % 2 == 0), 1'b0);
    repeat (8) tick(1'b0, 1'b0, 1'b0);
    check_val("glitch_credit", int'(credit), 0);
    for (int i = 1; i <= 8; i++) tick(1'b0, 1'b1, 1'b0);
    check_val("deb_latency_credit", int'(credit), 1);
    repeat (6) tick(1'b0, 1'b0, 1'b0);

    // advance without enough credit
    do_reset();
    sw_price = 5'd2;
    press(1'b1, 1'b0);
    den_seen = 0;
    press(1'b0, 1'b1);
    check_val("denied_count", den_seen, 1);
    check_val("denied_busy", int'(busy), 0);
    check_val("denied_credit", int'(credit), 1);
    check_val("denied_stage", int'(stage), 0);

    // full run through DONE, with a late advance landing on the last DONE cycle
    do_reset();
    sw_price = 5'd2;
    repeat (3) press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check_val("run_busy", int'(busy), 1);
    check_val("run_stage", int'(stage), 1);
    check_val("run_credit", int'(credit), 1);
    repeat (8) press(1'b0, 1'b1);
    check_val("run_last_stage", int'(stage), 9);
    den_seen = 0;
    done_seen = 0;
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b0, 1'b0, 1'b1);
    check_val("done_flag", int'(done), 1);
    check_val("done_stage", int'(stage), 9);
    repeat (6) tick(1'b0, 1'b0, 1'b0);
    check_val("done_cycles", done_seen, HOLD);
    check_val("post_done_stage", int'(stage), 0);
    check_val("post_done_busy", int'(busy), 0);
    check_val("post_done_denied", den_seen, 0);

    // credit saturation
    do_reset();
    repeat (35) press(1'b1, 1'b0);
    check_val("sat_credit", int'(credit), CMAX);

    // coin and advance together at start, then reset mid-run
    do_reset();
    sw_price = 5'd3;
    repeat (3) press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    check_val("simul_credit", int'(credit), 1);
    check_val("simul_stage", int'(stage), 1);
    repeat (4) press(1'b0, 1'b1);
    check_val("mid_stage", int'(stage), 5);
    tick(1'b1, 1'b0, 1'b0);
    check_val("midrst_stage", int'(stage), 0);
    check_val("midrst_credit", int'(credit), 0);
    check_val("midrst_busy", int'(busy), 0);

    // randomized bouncy buttons, price changes and occasional reset
    do_reset();
    rem[0] = 0; rem[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int n = 0; n < 2500; n++) begin
      if (n % 250 == 0) sw_price = W'($urandom_range(0, 3));
      for (int b = 0; b < 2; b++) begin
        if (rem[b] == 0) begin
          lvl[b] = int'($urandom_range(0, 1));
          rem[b] = int'($urandom_range(1, 10));
        end
        rem[b]--;
      end
      tick(1'($urandom_range(0, 399) == 0), 1'(lvl[0]), 1'(lvl[1]));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
